// File: rtl/hurricane_timer.sv
// hurricane_timer: gates, times and exits the range-hood hurricane mode (mode 3).
// Optional HURRICANE_ONCE_EN: allow a single hurricane run per power-on session.
module hurricane_timer #(
    parameter int unsigned CLK_HZ        = 100_000_000,
    parameter int unsigned HURRICANE_SEC = 60,
    parameter int unsigned RETURN_SEC    = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       machine_state,
    input  logic [2:0] mode_state,
    input  logic       menu_btn,
    output logic       hurricane_mode_enabled,
    output logic       return_state,
    output logic [7:0] countdown_sec,
    output logic       hurricane_used
);
    localparam int unsigned CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    typedef enum logic [1:0] {IDLE, RUN, EXIT, LOCKED} state_t;
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0] countdown_q, countdown_d;
    logic en_q, en_d, ret_q, ret_d, used_q, used_d, menu_prev_q, menu_prev_d;
    logic hurr, tick, menu_edge;
    assign hurr = mode_state == 3'b011;
    assign tick = cnt_q == CW'(CLK_HZ - 1);
    assign menu_edge = menu_btn & ~menu_prev_q;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        countdown_d = countdown_q;
        en_d = en_q;
        ret_d = ret_q;
        used_d = used_q;
        menu_prev_d = menu_btn;
        case (state_q)
            IDLE: begin
                en_d = 1'b1;
                if (hurr) begin
                    state_d = RUN;
                    countdown_d = 8'(HURRICANE_SEC);
                    cnt_d = '0;
                    ret_d = 1'b0;
                    used_d = 1'b1;
                end
            end
            RUN: begin
                cnt_d = tick ? '0 : cnt_q + 1'b1;
                // A menu press on the expiry tick takes priority and extends the run
                if (!hurr) begin
                    countdown_d = 8'd0;
                    ret_d = 1'b0;
`ifdef HURRICANE_ONCE_EN
                    state_d = LOCKED;
                    en_d = 1'b0;
`else
                    state_d = IDLE;
                    en_d = 1'b1;
`endif
                end else if (menu_edge && !ret_q) begin
                    ret_d = 1'b1;
                    countdown_d = 8'(RETURN_SEC);
                    cnt_d = '0;
                end else if (tick && countdown_q == 8'd1) begin
                    countdown_d = 8'd0;
                    en_d = 1'b0;
                    state_d = EXIT;
                end else if (tick) begin
                    countdown_d = countdown_q - 8'd1;
                end
            end
            EXIT: begin
                en_d = 1'b0;
                if (!hurr) begin
                    ret_d = 1'b0;
`ifdef HURRICANE_ONCE_EN
                    state_d = LOCKED;
`else
                    state_d = IDLE;
                    en_d = 1'b1;
`endif
                end
            end
            LOCKED: begin
                en_d = 1'b0;
                countdown_d = 8'd0;
            end
            default: state_d = IDLE;
        endcase
        if (!machine_state) begin
            state_d = IDLE;
            cnt_d = '0;
            countdown_d = 8'd0;
            en_d = 1'b1;
            ret_d = 1'b0;
            used_d = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            countdown_q <= 8'd0;
            en_q <= 1'b1;
            ret_q <= 1'b0;
            used_q <= 1'b0;
            menu_prev_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            countdown_q <= countdown_d;
            en_q <= en_d;
            ret_q <= ret_d;
            used_q <= used_d;
            menu_prev_q <= menu_prev_d;
        end
    end
    assign hurricane_mode_enabled = en_q;
    assign return_state = ret_q;
    assign countdown_sec = countdown_q;
    assign hurricane_used = used_q;
endmodule
